fir_iq_pingpong_buffer: RTL and testbench
=========================================

Name: fir_iq_pingpong_buffer

Overview:
- Upstream feeder for the FX2 slave-FIFO interface: captures the continuous FIR output stream ({I,Q} 32-bit at sample rate) into two 16-bit RAM banks.
- Ping-pong banking; FX2 drains one full bank per 512-byte EP6 packet while the other bank fills.
- Selected when the PC issues "FIRI"; ENABLE mirrors that source select.

Parameters:
PINGPONG_RAM_WIDTHAD, 8, log2 words per bank (256 words = 512 bytes = 128 IQ samples); must be >= 2
SYNC_STAGES, 2, synchroniser depth for ST_DATA_CLK

Ports:
REF_CLK_180  in  1  block clock, same as FX2 IFCLK
RST_N  in  1  asynchronous, active-low reset
ENABLE  in  1  1 = FIR path active; 0 = synchronous flush
ST_DATA  in  32  {I[15:0],Q[15:0]} from FIR
ST_DATA_CLK  in  1  sample-rate clock, asynchronous to REF_CLK_180
RD_READY  out  1  a full bank is available to the reader
RD_EN  in  1  consume current RD_DATA word (FX2 SLWR active)
RD_DATA  out  16  current word of reader bank (first-word-fall-through)
RD_LAST  out  1  RD_DATA is the final word of the bank
RD_BANK  out  1  index of bank being read
OVERFLOW  out  1  sticky: at least one sample dropped
DROP_CNT  out  16  dropped-sample count, saturates at 16'hFFFF

Behaviour:
- Reset (RST_N=0, async): all pointers 0, both banks empty, wr_bank=0, rd_bank=0, RD_READY=0, RD_DATA=0, RD_LAST=0, RD_BANK=0, OVERFLOW=0, DROP_CNT=0. Synchroniser flops cleared.
- Sample capture:
  - ST_DATA_CLK passes through SYNC_STAGES flops plus one edge flop.
  - A sample event is one cycle on the detected rising edge; ST_DATA is registered in that cycle.
  - ST_DATA must be settled within SYNC_STAGES cycles of the edge.
  - ST_DATA_CLK period must be >= 8 REF_CLK_180 cycles.
- Write FSM, states W_WAIT, W_I, W_Q, W_STALL:
  - W_WAIT: on sample event, to W_I; if ENABLE=0 the event is ignored.
  - W_I: write I (ST_DATA[31:16]) at even address wr_ptr, then to W_Q.
  - W_Q: write Q (ST_DATA[15:0]) at wr_ptr+1. A sample is never split across banks.
  - Bank full (wr_ptr wraps to 0) with the other bank empty: set full[wr_bank], toggle wr_bank, return to W_WAIT.
  - Bank full with the other bank still full: set full[wr_bank], go to W_STALL.
  - W_STALL: every sample event increments DROP_CNT (saturating) and sets OVERFLOW. When the reader releases a bank, toggle wr_bank and go to W_WAIT the next cycle.
  - Release in the same cycle the bank completes: switch with no stall and no drop.
- Read side:
  - RD_READY=1 when full[rd_bank]=1 and the post-release gap has elapsed.
  - With RD_READY=1, RD_DATA = word rd_ptr of rd_bank and RD_LAST = (rd_ptr == 2^W-1).
  - RD_EN=1 with RD_READY=1 in cycle n: RD_DATA shows word rd_ptr+1 in cycle n+1. Implementation prefetches from synchronous RAM to meet this.
  - RD_EN with RD_LAST=1: clear full[rd_bank], toggle rd_bank, rd_ptr=0, RD_READY=0 for at least 1 cycle. RD_READY reasserts afterwards only if the new bank is full.
  - RD_EN while RD_READY=0: ignored; RD_DATA holds its value.
  - The reader always drains banks in fill order (strict alternation starting at bank 0).
- ENABLE=0 (synchronous, any state, including mid-bank or mid-read): same clear as reset except the synchroniser. Partial samples and banks are discarded.
- Bank depth: samples per bank = 2^(W-1); words per bank = 2^W. All pointer arithmetic is modulo 2^W.

Decomposition:
- Package fir_buf_pkg:
  - write-state enum (W_WAIT, W_I, W_Q, W_STALL)
  - DROP_CNT_MAX constant
  - word-order constants (I_WORD=0, Q_WORD=1)
- Sub-module dp_ram16 (simple dual-port 16-bit RAM, one write port, one registered read port, depth 2^(W+1)). The bank bit is the address MSB.
- Synchroniser and edge detect stay inline.

Test Plan:
- Fill: W=8, 128 samples ST_DATA=32'hAAAA0000+k -> RD_READY rises, RD_BANK=0. Draining 256 words with continuous RD_EN yields AAAA,0000,AAAA,0001,... and RD_LAST on word 255 only.
- Ping-pong: 256 continuous samples, read bank 0 while bank 1 fills -> bank 1 yields samples 128..255. RD_READY low >= 1 cycle between banks. DROP_CNT=0.
- Overflow: 300 samples with RD_EN=0 -> both banks full, DROP_CNT=44, OVERFLOW=1. After draining bank 0, the next sample lands at bank 0 word 0.
- Simultaneous: bank 1 completes in the same cycle bank 0's last word is read -> no drop. Next sample written to bank 0 word 0.
- Flush: ENABLE=0 for 1 cycle after 50 samples -> RD_READY=0, DROP_CNT=0. The next 128 samples form a clean bank 0 starting at the first new sample.
- Async reset mid-read (asserted at word 100) -> all outputs 0 immediately. After release, normal fill resumes at bank 0.

Source files
------------

// File: rtl/fir_buf_pkg.sv
// fir_buf_pkg: shared types and constants for the FIR IQ ping-pong buffer
package fir_buf_pkg;
  typedef enum logic [1:0] {W_WAIT, W_I, W_Q, W_STALL} wstate_t;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;
  localparam logic I_WORD = 1'b0;
  localparam logic Q_WORD = 1'b1;
endpackage

// File: rtl/fir_iq_pingpong_buffer_dp_ram16.sv
// dp_ram16: simple dual-port 16-bit RAM, one write port and one registered read port
module dp_ram16 #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [0:(1<<AW)-1];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fir_iq_pingpong_buffer.sv
// fir_iq_pingpong_buffer: captures the FIR {I,Q} stream into two RAM banks drained alternately by the FX2
module fir_iq_pingpong_buffer
  import fir_buf_pkg::*;
#(
  parameter int PINGPONG_RAM_WIDTHAD = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        REF_CLK_180,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic [31:0] ST_DATA,
  input  logic        ST_DATA_CLK,
  output logic        RD_READY,
  input  logic        RD_EN,
  output logic [15:0] RD_DATA,
  output logic        RD_LAST,
  output logic        RD_BANK,
  output logic        OVERFLOW,
  output logic [15:0] DROP_CNT
);
  localparam int W = PINGPONG_RAM_WIDTHAD;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic edge_q, edge_d;
  logic [31:0] sample_q, sample_d;
  wstate_t state_q, state_d;
  logic [W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
  logic rd_ready_q, rd_ready_d, ovf_q, ovf_d;
  logic [15:0] drop_q, drop_d, hold_q, hold_d, ram_q, wdata;
  logic event_s, consume, release_s, other_free, bank_done, we;
  logic [W:0] waddr, raddr;

  always_comb begin
    sync_d = SYNC_STAGES'({sync_q, ST_DATA_CLK});
    edge_d = sync_q[SYNC_STAGES-1];
    event_s = sync_q[SYNC_STAGES-1] & ~edge_q;
    sample_d = event_s ? ST_DATA : sample_q;
    consume = RD_EN & rd_ready_q;
    RD_LAST = rd_ready_q & (&rd_ptr_q);
    release_s = consume & RD_LAST;
    rd_ptr_d = consume ? rd_ptr_q + W'(1) : rd_ptr_q;
    rd_bank_d = rd_bank_q ^ release_s;
    bank_done = (state_q == W_Q) & (&wr_ptr_q[W-1:1]) & (wr_ptr_q[0] == Q_WORD);
    // a bank the reader frees in this very cycle counts as free, so no stall
    other_free = ~full_q[~wr_bank_q] | (release_s & (rd_bank_q != wr_bank_q));
    for (int b = 0; b < 2; b++)
      full_d[b] = ~(release_s & (rd_bank_q == b[0])) & (full_q[b] | (bank_done & (wr_bank_q == b[0])));
    rd_ready_d = full_d[rd_bank_d] & ~release_s;
    RD_DATA = rd_ready_q ? ram_q : hold_q;
    hold_d = RD_DATA;
    we = ENABLE & ((state_q == W_I) | (state_q == W_Q));
    waddr = {wr_bank_q, wr_ptr_q};
    wdata = (wr_ptr_q[0] == I_WORD) ? sample_q[31:16] : sample_q[15:0];
    raddr = {rd_bank_d, rd_ptr_d};
  end

  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    drop_d = drop_q;
    ovf_d = ovf_q;
    case (state_q)
      W_WAIT: state_d = event_s ? W_I : W_WAIT;
      W_I: begin
        state_d = W_Q;
        wr_ptr_d = wr_ptr_q + W'(1);
      end
      W_Q: begin
        wr_ptr_d = wr_ptr_q + W'(1);
        state_d = (bank_done & ~other_free) ? W_STALL : W_WAIT;
        wr_bank_d = wr_bank_q ^ (bank_done & other_free);
      end
      default: begin
        drop_d = (event_s & (drop_q != DROP_CNT_MAX)) ? drop_q + 16'd1 : drop_q;
        ovf_d = ovf_q | event_s;
        state_d = other_free ? W_WAIT : W_STALL;
        wr_bank_d = wr_bank_q ^ other_free;
      end
    endcase
  end

  always_ff @(posedge REF_CLK_180 or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      sample_q <= '0;
      state_q <= W_WAIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q <= '0;
      rd_ready_q <= 1'b0;
      ovf_q <= 1'b0;
      drop_q <= '0;
      hold_q <= '0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
      sample_q <= sample_d;
      if (!ENABLE) begin
        state_q <= W_WAIT;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        wr_bank_q <= 1'b0;
        rd_bank_q <= 1'b0;
        full_q <= '0;
        rd_ready_q <= 1'b0;
        ovf_q <= 1'b0;
        drop_q <= '0;
        hold_q <= '0;
      end else begin
        state_q <= state_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        wr_bank_q <= wr_bank_d;
        rd_bank_q <= rd_bank_d;
        full_q <= full_d;
        rd_ready_q <= rd_ready_d;
        ovf_q <= ovf_d;
        drop_q <= drop_d;
        hold_q <= hold_d;
      end
    end
  end

  dp_ram16 #(.AW(W + 1)) u_ram (
    .clk  (REF_CLK_180),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(ram_q)
  );

  assign RD_READY = rd_ready_q;
  assign RD_BANK = rd_bank_q;
  assign OVERFLOW = ovf_q;
  assign DROP_CNT = drop_q;
endmodule

// File: tb/tb_fir_iq_pingpong_buffer.sv
// tb_fir_iq_pingpong_buffer: directed fill, ping-pong, overflow, simultaneous-release, flush and reset checks
module tb_fir_iq_pingpong_buffer;
  localparam int WORDS = 256;
  logic REF_CLK_180 = 1'b0;
  logic RST_N, ENABLE, ST_DATA_CLK, RD_EN;
  logic [31:0] ST_DATA;
  logic RD_READY, RD_LAST, RD_BANK, OVERFLOW;
  logic [15:0] RD_DATA, DROP_CNT;
  int passed = 0;
  int total = 0;

  fir_iq_pingpong_buffer #(.PINGPONG_RAM_WIDTHAD(8), .SYNC_STAGES(2)) dut (
    .REF_CLK_180(REF_CLK_180),
    .RST_N      (RST_N),
    .ENABLE     (ENABLE),
    .ST_DATA    (ST_DATA),
    .ST_DATA_CLK(ST_DATA_CLK),
    .RD_READY   (RD_READY),
    .RD_EN      (RD_EN),
    .RD_DATA    (RD_DATA),
    .RD_LAST    (RD_LAST),
    .RD_BANK    (RD_BANK),
    .OVERFLOW   (OVERFLOW),
    .DROP_CNT   (DROP_CNT)
  );

  always #5 REF_CLK_180 = ~REF_CLK_180;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge REF_CLK_180);
    #1;
  endtask

  function automatic logic [31:0] smp(input logic [31:0] base, input logic [31:0] inc, input int k);
    return base + inc * 32'(k);
  endfunction

  function automatic logic [15:0] exp_word(input logic [31:0] base, input logic [31:0] inc, input int start, input int w);
    logic [31:0] s;
    s = smp(base, inc, start + w / 2);
    return (w % 2 == 0) ? s[31:16] : s[15:0];
  endfunction

  task automatic sample(input logic [31:0] d);
    tick;
    ST_DATA = d;
    ST_DATA_CLK = 1'b1;
    repeat (4) tick;
    ST_DATA_CLK = 1'b0;
    repeat (4) tick;
  endtask

  task automatic send(input logic [31:0] base, input logic [31:0] inc, input int start, input int n);
    for (int k = 0; k < n; k++) sample(smp(base, inc, start + k));
  endtask

  task automatic flush;
    tick;
    ENABLE = 1'b0;
    tick;
    ENABLE = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (RD_READY !== 1'b1 && n < 3000) begin
      tick;
      n++;
    end
    check({tag, "_wait"}, 32'(RD_READY), 32'd1);
  endtask

  task automatic drain(input string tag, input logic [31:0] base, input logic [31:0] inc,
                       input int start, input logic bank, input int n);
    check({tag, "_bank"}, 32'(RD_BANK), 32'(bank));
    for (int w = 0; w < n; w++) begin
      check($sformatf("%s_w%0d", tag, w), {14'd0, RD_READY, RD_LAST, RD_DATA},
            {14'd0, 1'b1, w == WORDS - 1, exp_word(base, inc, start, w)});
      RD_EN = 1'b1;
      tick;
    end
    RD_EN = 1'b0;
    if (n == WORDS) check({tag, "_gap"}, 32'(RD_READY), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    ENABLE = 1'b1;
    ST_DATA = '0;
    ST_DATA_CLK = 1'b0;
    RD_EN = 1'b0;
    repeat (3) tick;
    check("rst_flags", 32'({RD_READY, RD_LAST, RD_BANK, OVERFLOW}), 32'd0);
    check("rst_data", 32'(RD_DATA), 32'd0);
    check("rst_drop", 32'(DROP_CNT), 32'd0);
    RST_N = 1'b1;
    tick;
    RD_EN = 1'b1;
    tick;
    RD_EN = 1'b0;
    check("idle_rd_en", {15'd0, RD_READY, RD_DATA}, 32'd0);

    send(32'hAAAA_0000, 32'd1, 0, 128);
    check("fill_ready", 32'(RD_READY), 32'd1);
    check("fill_drop", 32'(DROP_CNT), 32'd0);
    drain("fill", 32'hAAAA_0000, 32'd1, 0, 1'b0, WORDS);
    RD_EN = 1'b1;
    tick;
    RD_EN = 1'b0;
    check("fill_hold", 32'(RD_DATA), 32'h007F);
    check("fill_nextbank", 32'(RD_BANK), 32'd1);

    flush;
    fork
      send(32'h1000_2000, 32'h0001_0001, 0, 256);
      begin
        wait_ready("pp0");
        drain("pp0", 32'h1000_2000, 32'h0001_0001, 0, 1'b0, WORDS);
        wait_ready("pp1");
        drain("pp1", 32'h1000_2000, 32'h0001_0001, 128, 1'b1, WORDS);
      end
    join
    check("pp_drop", 32'(DROP_CNT), 32'd0);
    check("pp_ovf", 32'(OVERFLOW), 32'd0);

    flush;
    send(32'h3000_4000, 32'h0001_0003, 0, 128);
    drain("sim0", 32'h3000_4000, 32'h0001_0003, 0, 1'b0, WORDS - 1);
    send(32'h3000_4000, 32'h0001_0003, 128, 127);
    tick;
    ST_DATA = smp(32'h3000_4000, 32'h0001_0003, 255);
    ST_DATA_CLK = 1'b1;
    repeat (4) tick;
    ST_DATA_CLK = 1'b0;
    check("sim_last", {14'd0, RD_READY, RD_LAST, RD_DATA},
          {14'd0, 1'b1, 1'b1, exp_word(32'h3000_4000, 32'h0001_0003, 0, WORDS - 1)});
    RD_EN = 1'b1;
    tick;
    RD_EN = 1'b0;
    repeat (3) tick;
    check("sim_drop", 32'(DROP_CNT), 32'd0);
    check("sim_ovf", 32'(OVERFLOW), 32'd0);
    wait_ready("sim1");
    drain("sim1", 32'h3000_4000, 32'h0001_0003, 128, 1'b1, WORDS);
    send(32'h3000_4000, 32'h0001_0003, 256, 128);
    wait_ready("sim2");
    drain("sim2", 32'h3000_4000, 32'h0001_0003, 256, 1'b0, WORDS);

    flush;
    send(32'h5000_0000, 32'h0003_0001, 0, 300);
    check("ovf_drop", 32'(DROP_CNT), 32'd44);
    check("ovf_flag", 32'(OVERFLOW), 32'd1);
    check("ovf_ready", 32'(RD_READY), 32'd1);
    drain("ovf0", 32'h5000_0000, 32'h0003_0001, 0, 1'b0, WORDS);
    tick;
    check("ovf0_reassert", 32'(RD_READY), 32'd1);
    send(32'h5000_0000, 32'h0003_0001, 300, 128);
    drain("ovf1", 32'h5000_0000, 32'h0003_0001, 128, 1'b1, WORDS);
    tick;
    check("ovf1_reassert", 32'(RD_READY), 32'd1);
    drain("ovf2", 32'h5000_0000, 32'h0003_0001, 300, 1'b0, WORDS);
    check("ovf_drop_hold", 32'(DROP_CNT), 32'd44);
    check("ovf_flag_hold", 32'(OVERFLOW), 32'd1);

    send(32'hEEEE_0000, 32'd1, 0, 50);
    flush;
    check("fl_ready", 32'(RD_READY), 32'd0);
    check("fl_drop", 32'(DROP_CNT), 32'd0);
    check("fl_ovf", 32'(OVERFLOW), 32'd0);
    check("fl_bank", 32'(RD_BANK), 32'd0);
    send(32'h7000_8000, 32'h0001_0001, 0, 128);
    check("fl_fill_ready", 32'(RD_READY), 32'd1);
    drain("fl", 32'h7000_8000, 32'h0001_0001, 0, 1'b0, WORDS);

    flush;
    send(32'h6666_0000, 32'h0001_0001, 0, 128);
    drain("rmid", 32'h6666_0000, 32'h0001_0001, 0, 1'b0, 100);
    #2 RST_N = 1'b0;
    #1;
    check("rmid_flags", 32'({RD_READY, RD_LAST, RD_BANK, OVERFLOW}), 32'd0);
    check("rmid_data", 32'(RD_DATA), 32'd0);
    check("rmid_drop", 32'(DROP_CNT), 32'd0);
    tick;
    tick;
    RST_N = 1'b1;
    send(32'h9000_1000, 32'd1, 0, 128);
    wait_ready("post");
    drain("post", 32'h9000_1000, 32'd1, 0, 1'b0, WORDS);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
